// File: rtl/multicycle_ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle RV32I control FSM.
//   - state encoding for the controller sequence
//   - RV32I major opcode constants
//   - pc_sel / wb_sel / alu_op encodings
//   - opcode_legal(): which major opcodes the controller executes
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] PC_SEL_PC4  = 2'b00;
    localparam logic [1:0] PC_SEL_ALU  = 2'b01;
    localparam logic [1:0] PC_SEL_JALR = 2'b10;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;
    localparam logic [1:0] WB_SEL_IMM = 2'b11;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [2:0] F3_SHR   = 3'b101;

    function automatic logic opcode_legal(input logic [6:0] op);
        logic ok;
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: ok = 1'b1;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_op_dec.sv
// alu_op_dec: combinational ALU control decode from the held IR fields.
//   opcode, func3, func7 : in  - instruction fields from ins_dec
//   alu_op               : out - {sub/sra bit, func3}, 0000 = ADD
//   alu_a_sel            : out - 0 = rs1, 1 = PC
//   alu_b_sel            : out - 0 = rs2, 1 = imm
import ctrl_pkg::*;

module alu_op_dec (
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output logic [3:0] alu_op,
    output logic       alu_a_sel,
    output logic       alu_b_sel
);

    // Only func7[5] selects SUB/SRA; the rest of func7 is immediate bits here.
    logic unused_func7;
    assign unused_func7 = ^{func7[6], func7[4:0]};

    always_comb begin
        alu_op    = ALU_ADD;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        case (opcode)
            OP_R: begin
                alu_op = {func7[5], func3};
            end
            OP_IMM: begin
                // func7[5] is part of the immediate except for shift-right,
                // where it distinguishes SRAI from SRLI.
                alu_b_sel = 1'b1;
                alu_op    = {(func3 == F3_SHR) ? func7[5] : 1'b0, func3};
            end
            OP_LOAD, OP_STORE, OP_JALR: begin
                alu_b_sel = 1'b1;
            end
            OP_AUIPC, OP_JAL, OP_BRANCH: begin
                // ALU computes PC+imm: target for JAL/taken branch, result for AUIPC.
                alu_a_sel = 1'b1;
                alu_b_sel = 1'b1;
            end
            default: begin
                alu_op = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I control FSM.
// Sequences IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) around a shared
// instruction/data memory port; drives all datapath enables and selects.
//   clk, reset          : clock (rising edge), asynchronous active-high reset
//   opcode/func3/func7  : held IR fields from ins_dec
//   mem_ready           : memory completes the current request
//   br_taken            : branch comparator result
//   mem_req/mem_we      : memory request / store qualifier
//   addr_sel            : memory address 0 = PC, 1 = ALU
//   ir_we, pc_we, pc_sel: IR load, PC update and PC source
//   alu_a_sel/b_sel/op  : ALU operand selects and operation
//   reg_we, wb_sel      : register-file write and write-back source
//   retire, instret     : completion pulse and retired count
//   trap                : sticky illegal-instruction flag
import ctrl_pkg::*;

module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic [3:0]       alu_op,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap
);

    state_e           state_q, state_d;
    logic             trap_q, trap_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [3:0] dec_alu_op;
    logic       dec_a_sel;
    logic       dec_b_sel;

    alu_op_dec u_alu_op_dec (
        .opcode    (opcode),
        .func3     (func3),
        .func7     (func7),
        .alu_op    (dec_alu_op),
        .alu_a_sel (dec_a_sel),
        .alu_b_sel (dec_b_sel)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            trap_q    <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            trap_q    <= trap_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        trap_d    = trap_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_PC4;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        alu_op    = ALU_ADD;
        reg_we    = 1'b0;
        wb_sel    = WB_SEL_ALU;
        retire    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (opcode_legal(opcode)) begin
                    state_d = ST_EXEC;
                end else begin
                    trap_d  = 1'b1;
                    state_d = ST_TRAP;
                end
            end

            ST_EXEC: begin
                alu_a_sel = dec_a_sel;
                alu_b_sel = dec_b_sel;
                alu_op    = dec_alu_op;
                case (opcode)
                    OP_BRANCH: begin
                        // Branch target PC+imm comes straight from the ALU.
                        pc_we   = 1'b1;
                        pc_sel  = br_taken ? PC_SEL_ALU : PC_SEL_PC4;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    OP_LOAD, OP_STORE: state_d = ST_MEM;
                    default:           state_d = ST_WB;
                endcase
            end

            ST_MEM: begin
                // ALU keeps producing the effective address while the request waits.
                alu_a_sel = dec_a_sel;
                alu_b_sel = dec_b_sel;
                alu_op    = dec_alu_op;
                mem_req   = 1'b1;
                addr_sel  = 1'b1;
                mem_we    = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        pc_we   = 1'b1;
                        pc_sel  = PC_SEL_PC4;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end

            ST_WB: begin
                alu_a_sel = dec_a_sel;
                alu_b_sel = dec_b_sel;
                alu_op    = dec_alu_op;
                reg_we    = 1'b1;
                pc_we     = 1'b1;
                retire    = 1'b1;
                state_d   = ST_FETCH;
                case (opcode)
                    OP_LOAD:          wb_sel = WB_SEL_MEM;
                    OP_JAL, OP_JALR:  wb_sel = WB_SEL_PC4;
                    OP_LUI:           wb_sel = WB_SEL_IMM;
                    default:          wb_sel = WB_SEL_ALU;
                endcase
                case (opcode)
                    OP_JAL:  pc_sel = PC_SEL_ALU;
                    OP_JALR: pc_sel = PC_SEL_JALR;
                    default: pc_sel = PC_SEL_PC4;
                endcase
            end

            ST_TRAP: begin
                state_d = ST_TRAP;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        instret_d = retire ? instret_q + {{(CNT_W-1){1'b0}}, 1'b1} : instret_q;
    end

    assign instret = instret_q;
    assign trap    = trap_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic             mem_ready;
    logic             br_taken;
    logic             mem_req;
    logic             mem_we;
    logic             addr_sel;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             alu_a_sel;
    logic             alu_b_sel;
    logic [3:0]       alu_op;
    logic             reg_we;
    logic [1:0]       wb_sel;
    logic             retire;
    logic [CNT_W-1:0] instret;
    logic             trap;

    int checks   = 0;
    int failures = 0;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .func3     (func3),
        .func7     (func7),
        .mem_ready (mem_ready),
        .br_taken  (br_taken),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .alu_a_sel (alu_a_sel),
        .alu_b_sel (alu_b_sel),
        .alu_op    (alu_op),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .retire    (retire),
        .instret   (instret),
        .trap      (trap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        br;
        int          mem_wait;
        logic [3:0]  exp_alu;
        logic        exp_a;
        logic        exp_b;
        logic [1:0]  exp_wb;
        logic [1:0]  exp_pc;
        logic        exp_reg_we;
        logic        exp_mem_we;
        int          exp_cycles;
        int          exp_mem_cyc;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called on a falling edge with the DUT in FETCH; returns on the falling
    // edge after the instruction retires (DUT back in FETCH).
    task automatic run_vec(input vec_t v);
        int               wait_left;
        int               mem_cyc;
        bit               done;
        logic [CNT_W-1:0] ir0;
        opcode    = v.instr[6:0];
        func3     = v.instr[14:12];
        func7     = v.instr[31:25];
        br_taken  = v.br;
        wait_left = v.mem_wait;
        mem_cyc   = 0;
        done      = 1'b0;
        ir0       = instret;
        for (int c = 0; c < 20 && !done; c++) begin
            mem_ready = 1'b0;
            #1;
            if (mem_req && addr_sel) begin
                if (wait_left > 0) wait_left--;
                else mem_ready = 1'b1;
            end else if (mem_req) begin
                mem_ready = 1'b1;
            end
            #1;
            if (mem_req && !addr_sel) begin
                chk({v.name, " fetch mem_we"}, 32'(mem_we), 32'd0);
                chk({v.name, " fetch ir_we"}, 32'(ir_we), 32'(mem_ready));
            end
            if (mem_req && addr_sel) begin
                mem_cyc++;
                chk({v.name, " mem_we"}, 32'(mem_we), 32'(v.exp_mem_we));
            end
            if (c == 2) begin
                chk({v.name, " alu_op"}, 32'(alu_op), 32'(v.exp_alu));
                chk({v.name, " alu_a_sel"}, 32'(alu_a_sel), 32'(v.exp_a));
                chk({v.name, " alu_b_sel"}, 32'(alu_b_sel), 32'(v.exp_b));
            end
            if (retire) begin
                done = 1'b1;
                chk({v.name, " pc_we"}, 32'(pc_we), 32'd1);
                chk({v.name, " pc_sel"}, 32'(pc_sel), 32'(v.exp_pc));
                chk({v.name, " reg_we"}, 32'(reg_we), 32'(v.exp_reg_we));
                chk({v.name, " wb_sel"}, 32'(wb_sel), 32'(v.exp_wb));
                chk({v.name, " cycles"}, 32'(c + 1), 32'(v.exp_cycles));
                chk({v.name, " mem cycles"}, 32'(mem_cyc), 32'(v.exp_mem_cyc));
            end else begin
                if (pc_we) chk({v.name, " early pc_we"}, 32'(pc_we), 32'd0);
            end
            @(negedge clk);
        end
        if (!done) chk({v.name, " retire timeout"}, 32'd0, 32'd1);
        chk({v.name, " instret"}, instret, ir0 + 32'd1);
        mem_ready = 1'b0;
    endtask

    vec_t vecs[16];

    initial begin
        //                name     instr        br  wait alu      a     b     wb     pc     rwe   mwe  cyc mc
        vecs[0]  = '{"ADD",   32'h002081B3, 1'b0, 0, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 4, 0};
        vecs[1]  = '{"SUB",   32'h402081B3, 1'b0, 0, 4'b1000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 4, 0};
        vecs[2]  = '{"SRAI",  32'h4020D193, 1'b0, 0, 4'b1101, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 4, 0};
        vecs[3]  = '{"SRLI",  32'h0020D193, 1'b0, 0, 4'b0101, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 4, 0};
        vecs[4]  = '{"ADDIN", 32'hC0008193, 1'b0, 0, 4'b0000, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 4, 0};
        vecs[5]  = '{"LW",    32'h0000A183, 1'b0, 2, 4'b0000, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 7, 3};
        vecs[6]  = '{"LW0",   32'h0000A183, 1'b0, 0, 4'b0000, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 5, 1};
        vecs[7]  = '{"SW",    32'h0020A023, 1'b0, 0, 4'b0000, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 4, 1};
        vecs[8]  = '{"SW1",   32'h0020A023, 1'b0, 1, 4'b0000, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 5, 2};
        vecs[9]  = '{"BEQT",  32'h00208063, 1'b1, 0, 4'b0000, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 3, 0};
        vecs[10] = '{"BEQN",  32'h00208063, 1'b0, 0, 4'b0000, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 3, 0};
        vecs[11] = '{"JAL",   32'h000000EF, 1'b0, 0, 4'b0000, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 1'b0, 4, 0};
        vecs[12] = '{"JALR",  32'h000100E7, 1'b0, 0, 4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 4, 0};
        vecs[13] = '{"LUI",   32'h000011B7, 1'b0, 0, 4'b0000, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 4, 0};
        vecs[14] = '{"AUIPC", 32'h00001197, 1'b0, 0, 4'b0000, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 4, 0};
        vecs[15] = '{"SRA",   32'h4020D1B3, 1'b0, 0, 4'b1101, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 4, 0};

        reset     = 1'b1;
        opcode    = 7'd0;
        func3     = 3'd0;
        func7     = 7'd0;
        mem_ready = 1'b1;
        br_taken  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset pc_we", 32'(pc_we), 32'd0);
        chk("reset instret", instret, 32'd0);
        chk("reset trap", 32'(trap), 32'd0);

        reset     = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("idle mem_req", 32'(mem_req), 32'd0);
        chk("idle ir_we", 32'(ir_we), 32'd0);
        @(negedge clk);
        chk("first fetch mem_req", 32'(mem_req), 32'd1);
        chk("first fetch addr_sel", 32'(addr_sel), 32'd0);

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);
        chk("instret after table", instret, 32'd16);

        // Reset asserted while FETCH waits on memory.
        mem_ready = 1'b0;
        #1;
        chk("fetch wait mem_req", 32'(mem_req), 32'd1);
        chk("fetch wait ir_we", 32'(ir_we), 32'd0);
        @(negedge clk);
        chk("fetch wait2 mem_req", 32'(mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midreset mem_req", 32'(mem_req), 32'd0);
        chk("midreset instret", instret, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("restart idle mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("restart fetch mem_req", 32'(mem_req), 32'd1);
        run_vec(vecs[0]);
        chk("restart instret", instret, 32'd1);

        // Illegal opcode (ECALL) traps and halts.
        opcode    = 7'h73;
        func3     = 3'd0;
        func7     = 7'd0;
        mem_ready = 1'b1;
        #1;
        chk("ecall fetch ir_we", 32'(ir_we), 32'd1);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("ecall decode trap", 32'(trap), 32'd0);
        @(negedge clk);
        chk("ecall trap set", 32'(trap), 32'd1);
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("trap mem_req", 32'(mem_req), 32'd0);
            chk("trap pc_we", 32'(pc_we), 32'd0);
            chk("trap retire", 32'(retire), 32'd0);
            @(negedge clk);
        end
        chk("trap sticky", 32'(trap), 32'd1);
        chk("trap instret", instret, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("trap reset clears", 32'(trap), 32'd0);
        chk("trap reset instret", instret, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("post-trap fetch mem_req", 32'(mem_req), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
